// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the multicycle RV32I core:
//            controller state encoding, ALU operation codes, immediate
//            formats, major opcodes and the ALU-op classes that the
//            controller hands to the ALU decoder.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        EXECU    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        JALRADR  = 4'd11,
        JAL      = 4'd12,
        TRAP     = 4'd13
    } ctrl_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IT_R = 3'd0,
        IT_I = 3'd1,
        IT_S = 3'd2,
        IT_B = 3'd3,
        IT_U = 3'd4,
        IT_J = 3'd5
    } instr_type_enum;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU-op classes: plain add, branch compare, funct-field decode
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Immediate format selected purely from the opcode
    function automatic instr_type_enum instr_type_of(input logic [6:0] op);
        instr_type_enum t;
        case (op)
            OP_LOAD, OP_I, OP_JALR: t = IT_I;
            OP_STORE:               t = IT_S;
            OP_BRANCH:              t = IT_B;
            OP_LUI, OP_AUIPC:       t = IT_U;
            OP_JAL:                 t = IT_J;
            default:                t = IT_R;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALU operation decode.
// Ports    : alu_op      in  2  class from controller (add/branch/funct)
//            funct3      in  3  instr[14:12]
//            funct7b5    in  1  instr[30]
//            op5         in  1  op[5], distinguishes OP (R) from OP-IMM
//            alu_control out 4  alu_ctrl_e operation
// Revision : 1.0  initial release
// ============================================================================
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctrl_e  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    // SUB exists only for register-register ops; ADDI ignores bit 30
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Control FSM for the multicycle RV32I core. Sequences the shared
//            memory port, ALU, instruction register, register file and
//            immediate extender; all outputs are combinational from state.
// Ports    : clk, rst_n (async active-low)
//            op, funct3, funct7b5   instruction fields from IR
//            zero                   ALU zero flag
//            mem_ready              memory handshake (MEM_WAIT_EN only)
//            pc_write, adr_src, mem_write, ir_write, reg_write,
//            result_src, alu_src_a, alu_src_b, alu_control,
//            instr_type, illegal    datapath controls / trap flag
// Config   : MEM_WAIT_EN - adds mem_ready; FETCH, MEMREAD and MEMWRITE
//            stall until it is high.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [6:0]     op,
    input  logic [2:0]     funct3,
    input  logic           funct7b5,
    input  logic           zero,
`ifdef MEM_WAIT_EN
    input  logic           mem_ready,
`endif
    output logic           pc_write,
    output logic           adr_src,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_write,
    output logic [1:0]     result_src,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [3:0]     alu_control,
    output instr_type_enum instr_type,
    output logic           illegal
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    logic        w_mem_ready;
    logic        w_pc_write;
    logic        w_ir_write;
    logic [1:0]  w_alu_op;
    alu_ctrl_e   w_alu_ctrl;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        w_alu_op     = ALUOP_ADD;
        illegal      = 1'b0;
        case (r_state)
            FETCH: begin
                // PC+4 is routed straight from the ALU into the PC
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (w_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch/JAL target into ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = MEMADR;
                    OP_R:              w_next_state = EXECR;
                    OP_I:              w_next_state = EXECI;
                    OP_LUI, OP_AUIPC:  w_next_state = EXECU;
                    OP_BRANCH:         w_next_state = BRANCH;
                    OP_JAL:            w_next_state = JAL;
                    OP_JALR:           w_next_state = JALRADR;
                    default:           w_next_state = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (w_mem_ready) w_next_state = MEMWB;
            end
            MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                w_next_state = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (w_mem_ready) w_next_state = FETCH;
            end
            EXECR: begin
                alu_src_a    = 2'b10;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECU: begin
                // LUI adds the immediate to zero, AUIPC to the old PC
                alu_src_a    = (op == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b    = 2'b01;
                w_next_state = ALUWB;
            end
            ALUWB: begin
                reg_write    = 1'b1;
                w_next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_BRANCH;
                // beq/bne test equality; compare forms test the slt result,
                // where zero means "not less than"
                w_pc_write   = funct3[2] ? (~zero ^ funct3[0]) : (zero ^ funct3[0]);
                w_next_state = FETCH;
            end
            JALRADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = JAL;
            end
            JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = ALUWB;
            end
            TRAP: begin
                illegal      = 1'b1;
                w_next_state = TRAP;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // Architectural loads are suppressed while reset is held
    assign pc_write    = w_pc_write & rst_n;
    assign ir_write    = w_ir_write & rst_n;
    assign alu_control = w_alu_ctrl;
    assign instr_type  = instr_type_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (w_alu_ctrl)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. A per-instruction,
//            per-cycle script of expected controls is derived from the
//            instruction semantics and compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [6:0]     op;
    logic [2:0]     funct3;
    logic           funct7b5;
    logic           zero;
`ifdef MEM_WAIT_EN
    logic           mem_ready = 1'b1;
`endif
    logic           pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]     result_src, alu_src_a, alu_src_b;
    logic [3:0]     alu_control;
    instr_type_enum instr_type;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
`ifdef MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .instr_type  (instr_type),
        .illegal     (illegal)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [2:0] instr_type;
        logic       illegal;
    } ctl_t;

    function automatic ctl_t observed();
        ctl_t c;
        c.pc_write    = pc_write;
        c.adr_src     = adr_src;
        c.mem_write   = mem_write;
        c.ir_write    = ir_write;
        c.reg_write   = reg_write;
        c.result_src  = result_src;
        c.alu_src_a   = alu_src_a;
        c.alu_src_b   = alu_src_b;
        c.alu_control = alu_control;
        c.instr_type  = instr_type;
        c.illegal     = illegal;
        return c;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [2:0] fmt_of(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011, 7'b1100111: return IT_I;
            7'b0100011:                         return IT_S;
            7'b1100011:                         return IT_B;
            7'b0110111, 7'b0010111:             return IT_U;
            7'b1101111:                         return IT_J;
            default:                            return IT_R;
        endcase
    endfunction

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input logic is_reg);
        case (f3)
            3'd0:    return (is_reg && f7) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Branch outcome from the meaning of each branch: zero flag of the
    // subtraction for beq/bne, of the less-than result for the others
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0:       return z;        // beq: equal
            3'd1:       return !z;       // bne
            3'd4, 3'd6: return !z;       // blt/bltu: less-than result is 1
            default:    return z;        // bge/bgeu
        endcase
    endfunction

    function automatic logic [3:0] cmp_op(input logic [2:0] f3);
        if (f3[2:1] == 2'b10) return ALU_SLT;
        if (f3[2:1] == 2'b11) return ALU_SLTU;
        return ALU_SUB;
    endfunction

    function automatic ctl_t want_cycle(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic z, input int k);
        ctl_t e = '0;
        e.instr_type  = fmt_of(o);
        e.alu_control = ALU_ADD;
        if (k == 0) begin
            e.ir_write = 1'b1; e.pc_write = 1'b1; e.result_src = 2'b10; e.alu_src_b = 2'b10;
        end else if (k == 1) begin
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        end else begin
            case (o)
                7'b0000011: case (k)
                    2: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                    3: e.adr_src = 1'b1;
                    default: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
                endcase
                7'b0100011: case (k)
                    2: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                    default: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
                endcase
                7'b0110011: case (k)
                    2: begin e.alu_src_a = 2'b10; e.alu_control = arith_op(f3, f7, 1'b1); end
                    default: e.reg_write = 1'b1;
                endcase
                7'b0010011: case (k)
                    2: begin
                        e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                        e.alu_control = arith_op(f3, f7, 1'b0);
                    end
                    default: e.reg_write = 1'b1;
                endcase
                7'b0110111, 7'b0010111: case (k)
                    2: begin e.alu_src_a = (o == 7'b0110111) ? 2'b11 : 2'b01; e.alu_src_b = 2'b01; end
                    default: e.reg_write = 1'b1;
                endcase
                7'b1100011: begin
                    e.alu_src_a = 2'b10; e.alu_control = cmp_op(f3);
                    e.pc_write = branch_taken(f3, z);
                end
                7'b1101111: case (k)
                    2: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
                    default: e.reg_write = 1'b1;
                endcase
                7'b1100111: case (k)
                    2: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                    3: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
                    default: e.reg_write = 1'b1;
                endcase
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic int latency(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b1100111: return 5;
            7'b1100011:             return 3;
            default:                return 4;
        endcase
    endfunction

    // Controls seen while reset is held: fetch values without the loads
    function automatic ctl_t want_reset(input logic [6:0] o);
        ctl_t e = want_cycle(o, 3'd0, 1'b0, 1'b0, 0);
        e.ir_write = 1'b0;
        e.pc_write = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t obs, input ctl_t want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Entered just after a rising edge with the FSM in FETCH.
    // zsel < 0 randomises the zero flag, otherwise forces zsel[0].
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int ncyc, input int zsel, input string name);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int k = 0; k < ncyc; k++) begin
            zero = (zsel < 0) ? 1'($urandom) : zsel[0];
            @(negedge clk);
            check($sformatf("%s_c%0d", name, k), observed(), want_cycle(o, f3, f7, zero, k));
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                      7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; rst_n = 1'b0;

        // reset state
        repeat (2) begin
            @(negedge clk);
            check("reset", observed(), want_reset(7'd0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed instructions
        run_instr(7'b0010011, 3'd0, 1'b0, 4, -1, "addi");
        run_instr(7'b0000011, 3'd2, 1'b0, 5, -1, "lw");
        run_instr(7'b0100011, 3'd2, 1'b0, 4, -1, "sw");
        run_instr(7'b1100011, 3'd0, 1'b0, 3,  1, "beq_z1");
        run_instr(7'b1100011, 3'd1, 1'b0, 3,  1, "bne_z1");
        run_instr(7'b1100011, 3'd4, 1'b0, 3,  0, "blt_z0");
        run_instr(7'b1100011, 3'd7, 1'b0, 3,  0, "bgeu_z0");
        run_instr(7'b1100111, 3'd0, 1'b0, 5, -1, "jalr");
        run_instr(7'b1101111, 3'd0, 1'b0, 4, -1, "jal");
        run_instr(7'b0110011, 3'd0, 1'b1, 4, -1, "sub");
        run_instr(7'b0010011, 3'd0, 1'b1, 4, -1, "addi_b30");
        run_instr(7'b0010011, 3'd5, 1'b1, 4, -1, "srai");
        run_instr(7'b0110111, 3'd0, 1'b0, 4, -1, "lui");
        run_instr(7'b0010111, 3'd0, 1'b0, 4, -1, "auipc");

        // reset while the FSM sits in MEMREAD
        run_instr(7'b0000011, 3'd2, 1'b0, 3, -1, "lw_part");
        rst_n = 1'b0;
        #1;
        check("rst_memread_async", observed(), want_reset(7'b0000011));
        @(negedge clk);
        check("rst_memread_hold", observed(), want_reset(7'b0000011));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(7'b0000011, 3'd2, 1'b0, 5, -1, "lw_after_rst");

        // randomised instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            o  = legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            if (o == 7'b1100011 && f3[2:1] == 2'b01) f3 = f3 + 3'd2;
            run_instr(o, f3, 1'($urandom), latency(o), -1, $sformatf("rnd%0d", n));
        end

`ifdef MEM_WAIT_EN
        // stalled fetch: no loads until memory is ready
        op = 7'b0010011; funct3 = 3'd0; funct7b5 = 1'b0;
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("fetch_wait", observed(), want_reset(7'b0010011));
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        run_instr(7'b0010011, 3'd0, 1'b0, 4, -1, "addi_after_wait");
`endif

        // unsupported opcode: trap for good, released only by reset
        run_instr(7'b0000000, 3'd0, 1'b0, 12, -1, "trap");
        rst_n = 1'b0;
        #1;
        check("trap_rst", observed(), want_reset(7'b0000000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(7'b0010011, 3'd0, 1'b0, 4, -1, "addi_after_trap");
        run_instr(7'b0010011, 3'd6, 1'b0, 1, -1, "final_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I core. It sequences the shared datapath: one memory port, one ALU, the instruction register, the register file and the immediate extender. Each cycle it decodes the latched opcode, selects the immediate format through `instr_type`, and drives every datapath mux select and write enable.

## Interface
Parameters: none.
- `clk`  in  1  core clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  instr[6:0] from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag, combinational from current ALU result
- `mem_ready`  in  1  memory transfer done; port exists only with `MEM_WAIT_EN`
- `pc_write`  out  1  PC register load
- `adr_src`  out  1  0: address = PC, 1: address = ALUOut
- `mem_write`  out  1  data memory write strobe
- `ir_write`  out  1  instruction register and OldPC load
- `reg_write`  out  1  register-file write
- `result_src`  out  2  00 ALUOut, 01 memory data, 10 ALU result
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- `alu_src_b`  out  2  00 rs2, 01 immext, 10 constant 4
- `alu_control`  out  4  `alu_ctrl_e` (add, sub, and, or, xor, slt, sltu, sll, srl, sra)
- `instr_type`  out  `instr_type_enum`  immediate format for the extender
- `illegal`  out  1  unsupported opcode trapped; sticky until reset

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, ALUWB, BRANCH, JALRADR, JAL, TRAP.

**FETCH**
- adr_src=0, ir_write=1.
- ALU computes PC+4 (src_a=00, src_b=10, add); result_src=10; pc_write=1.
- Next state: DECODE.

**DECODE**
- ALU computes OldPC+immext (src_a=01, src_b=01, add) into ALUOut as the branch/JAL target.
- Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 or 0010111 → EXECU
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALRADR
  - otherwise → TRAP

**Memory path**
- MEMADR: rs1+imm. Next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1. Next MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Next FETCH.

**ALU path**
- EXECR: src_a=10, src_b=00, funct-decoded operation. Next ALUWB.
- EXECI: src_a=10, src_b=01, funct-decoded operation; funct7b5 is honoured only for shifts (funct3=101). Next ALUWB.
- EXECU: src_b=01, add; src_a=11 for LUI, 01 for AUIPC. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.

**Control flow**
- BRANCH: rs1−rs2 for funct3 000/001, slt for 100/101, sltu for 110/111. result_src=00. pc_write = zero XOR funct3[0] for beq/bne, and !zero XOR funct3[0] for the compare forms. Next FETCH.
- JALRADR: rs1+imm into ALUOut. Next JAL.
- JAL: result_src=00, pc_write=1; ALU computes OldPC+4. Next ALUWB.
- TRAP: all enables 0, illegal=1. Held until reset.

**Immediate format** (`instr_type`, combinational from op in every state)
- R for 0110011.
- I for loads, OP-IMM and JALR.
- S, B, U, J for their opcodes.
- R for unknown opcodes.

**Defaults:** every enable not named above is 0 in that state.

## Timing
- Reset: state=FETCH, illegal=0.
- Outputs are combinational from state; during reset they show FETCH values. ir_write and pc_write are gated by rst_n and are therefore 0 while reset is asserted.
- Latency in cycles, FETCH to next FETCH:
  - load 5
  - store 4
  - R / I / U 4
  - branch 3
  - JAL 4
  - JALR 5
- Reset asserted mid-instruction: the FSM returns to FETCH immediately and no partial write occurs after the reset edge.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - In FETCH, ir_write and pc_write assert only in the cycle where mem_ready=1.
  - In MEMWRITE, mem_write is held for every wait cycle.
  - Latencies grow by one cycle per wait cycle.
- `MEM_WAIT_EN` undefined: the mem_ready port is absent and memory is single-cycle.

## Structure
- Shared package `riscv_pkg`:
  - `ctrl_state_e`, `alu_ctrl_e`, `instr_type_enum`
  - opcode localparams: OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR
- One sub-module, `alu_decoder`: combinational, maps alu_op(2), funct3, funct7b5 and op[5] to alu_control.

## Test plan
- Reset mid-MEMREAD → next cycle is FETCH; reg_write stays 0; illegal=0.
- ADDI (op 0010011, funct3 000) → states FETCH, DECODE, EXECI, ALUWB; reg_write=1 only in cycle 4; instr_type=I.
- LW followed by SW → LW takes 5 cycles with result_src=01 in MEMWB; SW takes 4 cycles with mem_write=1 exactly once; instr_type=S for SW.
- BEQ with zero=1 → pc_write=1 in BRANCH. BNE with zero=1 → pc_write=0. Both take 3 cycles.
- JALR → JALRADR then JAL (pc_write=1), then ALUWB (reg_write=1); instr_type=I. JAL gives instr_type=J.
- Opcode 0000000 → TRAP; illegal=1 and all enables 0 for 10 cycles; released only by rst_n=0. With `MEM_WAIT_EN`, mem_ready=0 for 3 cycles in FETCH → ir_write asserts once, on the ready cycle.
